// File: rtl/blinker_pkg.sv
// Shared definitions for the multi-channel LED blinker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blinker_pkg;

  // Width of the configuration mode field
  localparam int MODE_W = 2;

  // Width of the configuration channel index (addresses up to 16 channels)
  localparam int CHAN_W = 4;

  // Channel operating modes, encoded exactly as they appear on cfg_mode_i
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // Value a channel's led takes on the edge it is written
  function automatic logic led_on_write(input mode_e m);
    return (m == MODE_ON) || (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/blinker_multi_if.sv
// Configuration port of the blinker: request bus plus ready and error pulse.
// Latency: n/a (signal bundle only).
// Backpressure: requester holds cfg_valid_i until it samples cfg_ready_o high.
interface blinker_multi_if
  import blinker_pkg::*;
#(
  parameter int CNT_W = 24
);

  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [CHAN_W-1:0] cfg_chan_i;
  logic [MODE_W-1:0] cfg_mode_i;
  logic [CNT_W-1:0]  cfg_period_i;
  logic              cfg_err_o;

  // Requester side (testbench, host logic)
  modport master (
    output cfg_valid_i,
    output cfg_chan_i,
    output cfg_mode_i,
    output cfg_period_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  // Blinker side
  modport slave (
    input  cfg_valid_i,
    input  cfg_chan_i,
    input  cfg_mode_i,
    input  cfg_period_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/blinker_chan.sv
// One blinker channel: mode, period, phase counter, led and oneshot busy flag.
// Latency: a write takes effect on the accepting edge; outputs are registered.
// Backpressure: none; a write strobe is always absorbed, en gates only counting.
module blinker_chan
  import blinker_pkg::*;
#(
  parameter int              CNT_W          = 24,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(499999)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [CNT_W-1:0]  i_period,
  output logic              o_led,
  output logic              o_busy
);

  mode_e            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_busy;

  mode_e            w_mode_new;
  logic             w_at_end;

  assign w_mode_new = mode_e'(i_mode);
  // A phase ends on the edge where the counter has reached the period,
  // so each phase spans period+1 enabled cycles.
  assign w_at_end   = (r_cnt == r_period);

  // Channel state machine: a write restarts the channel, otherwise count while enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= MODE_BLINK;
      r_period <= DEFAULT_PERIOD;
      r_cnt    <= '0;
      r_led    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_wr) begin
      // Writes win over counting and are honoured even when disabled
      r_mode   <= w_mode_new;
      r_period <= i_period;
      r_cnt    <= '0;
      r_led    <= led_on_write(w_mode_new);
      r_busy   <= (w_mode_new == MODE_ONESHOT);
    end else if (i_en) begin
      case (r_mode)
        MODE_OFF,
        MODE_ON: begin
          r_cnt <= '0;
        end
        MODE_BLINK: begin
          if (w_at_end) begin
            r_cnt <= '0;
            r_led <= ~r_led;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MODE_ONESHOT: begin
          // Pulse finished: fall back to OFF so the channel stays dark
          if (r_busy) begin
            if (w_at_end) begin
              r_mode <= MODE_OFF;
              r_cnt  <= '0;
              r_led  <= 1'b0;
              r_busy <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule

// File: rtl/blinker_multi.sv
// Multi-channel run-time configurable LED blinker with a valid/ready config port.
// Latency: config applies on the accepting edge; error pulse one cycle later.
// Backpressure: cfg_ready_o is low only while in reset / first cycle after it.
module blinker_multi
  import blinker_pkg::*;
#(
  parameter int               CHANNELS       = 4,
  parameter int               CNT_W          = 24,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(499999)
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                en_i,
  blinker_multi_if.slave      cfg,
  output logic [CHANNELS-1:0] led_o,
  output logic [CHANNELS-1:0] busy_o
);

  logic                r_ready;
  logic                r_err;

  logic                w_accept;
  logic                w_bad_chan;
  logic [CHANNELS-1:0] w_wr;

  assign w_accept   = cfg.cfg_valid_i & r_ready;
  // Compare one bit wider so CHANNELS = 16 never wraps
  assign w_bad_chan = ({1'b0, cfg.cfg_chan_i} >= (CHAN_W + 1)'(CHANNELS));

  // Ready rises on the first edge out of reset and then stays up
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Out-of-range channel: flag it for exactly the cycle after acceptance
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad_chan;
    end
  end

  assign cfg.cfg_ready_o = r_ready;
  assign cfg.cfg_err_o   = r_err;

  // Address decode and per-channel instances
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign w_wr[i] = w_accept && (cfg.cfg_chan_i == CHAN_W'(i));

    blinker_chan #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .i_clk    (system1000),
      .i_rst_n  (system1000_rstn),
      .i_en     (en_i),
      .i_wr     (w_wr[i]),
      .i_mode   (cfg.cfg_mode_i),
      .i_period (cfg.cfg_period_i),
      .o_led    (led_o[i]),
      .o_busy   (busy_o[i])
    );
  end

endmodule
